// File: rtl/mod_exp_pkg.sv
// rtl/mod_exp_pkg.sv - shared state encoding and sizing helpers for mod_exp_ctrl
package mod_exp_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    IDLE, SQR, SQR_W, GAP1, MUL, MUL_W, GAP2, NEXT, FIN
  } state_t;

  // Smallest counter width that can hold WIDTH-1 with headroom (2^CNT_W > WIDTH)
  function automatic int cnt_w_for(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - left-to-right square-and-multiply sequencer over an external modular_mult
// Optional CONST_TIME_EN: always issue the multiply, discarding it into a dummy register for clear bits.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_w_for(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] Z,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_A,
  output logic [WIDTH-1:0] mm_B,
  output logic [WIDTH-1:0] mm_N,
  input  logic [WIDTH-1:0] mm_Z,
  input  logic             mm_done
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, mr, er, nr;
  logic [CNT_W-1:0] idx;
`ifdef CONST_TIME_EN
  logic [WIDTH-1:0] d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Multiplier interface is decoded from state so an async reset drops it instantly
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b1;
    mm_start  = 1'b0;
    mm_A      = '0;
    mm_B      = '0;
    mm_N      = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (N == '0) ? FIN : SQR;
      end
      SQR, SQR_W: begin
        mm_start = 1'b1;
        mm_A     = r;
        mm_B     = r;
        mm_N     = nr;
        if (state == SQR)  state_nxt = SQR_W;
        else if (mm_done)  state_nxt = GAP1;
      end
      GAP1: begin
`ifdef CONST_TIME_EN
        state_nxt = MUL;
`else
        state_nxt = er[idx] ? MUL : NEXT;
`endif
      end
      MUL, MUL_W: begin
        mm_start = 1'b1;
        mm_A     = r;
        mm_B     = mr;
        mm_N     = nr;
        if (state == MUL)  state_nxt = MUL_W;
        else if (mm_done)  state_nxt = GAP2;
      end
      GAP2:    state_nxt = NEXT;
      NEXT:    state_nxt = (idx == '0) ? FIN : SQR;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r   <= '0;
      mr  <= '0;
      er  <= '0;
      nr  <= '0;
      idx <= '0;
      Z   <= '0;
      err <= 1'b0;
`ifdef CONST_TIME_EN
      d   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mr  <= M;
            er  <= E;
            nr  <= N;
            idx <= IDX_TOP;
            err <= (N == '0);
            r   <= (N == ONE) ? '0 : ONE;
            if (N == '0) Z <= '0;
          end
        end
        SQR_W: if (mm_done) r <= mm_Z;
        MUL_W: begin
          if (mm_done) begin
`ifdef CONST_TIME_EN
            if (er[idx]) r <= mm_Z;
            else         d <= mm_Z;
`else
            r <= mm_Z;
`endif
          end
        end
        NEXT: begin
          if (idx == '0) Z   <= r;
          else           idx <= idx - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb/tb_mod_exp_ctrl.sv - scoreboard bench for mod_exp_ctrl with a behavioural modular multiplier
module tb_mod_exp_ctrl;

  localparam int W      = 32;
  localparam int MM_LAT = 3;
  localparam int BUDGET = 3000;
`ifdef CONST_TIME_EN
  localparam int OPS_4_13 = 64;
  localparam int OPS_E0   = 64;
`else
  localparam int OPS_4_13 = 35;
  localparam int OPS_E0   = 32;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] m_in = '0, e_in = '0, n_in = '0;
  logic [W-1:0] z;
  logic         done, busy, err;
  logic         mm_start;
  logic [W-1:0] mm_a, mm_b, mm_n;
  logic [W-1:0] mm_z;
  logic         mm_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_z_q[$];
  bit           exp_err_q[$];

  mod_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .M(m_in), .E(e_in), .N(n_in),
    .Z(z), .done(done), .busy(busy), .err(err),
    .mm_start(mm_start), .mm_A(mm_a), .mm_B(mm_b), .mm_N(mm_n),
    .mm_Z(mm_z), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  // Behavioural modular_mult: result after MM_LAT cycles, done held while start stays high
  int lat_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= 0;
      mm_done <= 1'b0;
      mm_z    <= '0;
    end else if (!mm_start) begin
      lat_cnt <= 0;
      mm_done <= 1'b0;
    end else if (lat_cnt == MM_LAT) begin
      mm_done <= 1'b1;
      mm_z    <= (mm_n == '0) ? '0 :
                 W'(({32'b0, mm_a} * {32'b0, mm_b}) % {32'b0, mm_n});
    end else begin
      lat_cnt <= lat_cnt + 1;
    end
  end

  int   rise_total = 0;
  int   done_total = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    prev_start <= mm_start;
    if (mm_start && !prev_start) rise_total <= rise_total + 1;
    if (done) done_total <= done_total + 1;
  end

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m, e, n);
    logic [63:0] r, nn;
    if (n == '0) return '0;
    nn = {32'b0, n};
    r  = (n == 1) ? 64'd0 : 64'd1;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * {32'b0, m}) % nn;
    end
    return r[W-1:0];
  endfunction

  task automatic issue(input logic [W-1:0] m, e, n);
    @(negedge clk);
    m_in = m; e_in = e; n_in = n; start = 1'b1;
    exp_z_q.push_back(ref_modexp(m, e, n));
    exp_err_q.push_back(n == '0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pop_expected(output logic [W-1:0] ez, output bit ee);
    ez = (exp_z_q.size() > 0) ? exp_z_q.pop_front() : 'x;
    ee = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'bx;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({z, done, busy, err, mm_start, mm_a, mm_b, mm_n} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got z=%0d done=%b busy=%b err=%b mm_start=%b a=%0d b=%0d n=%0d, want all 0",
               z, done, busy, err, mm_start, mm_a, mm_b, mm_n);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int base; bit ok; logic [W-1:0] ez; bit ee;
    base = rise_total;
    issue(32'd4, 32'd13, 32'd497);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_timeout: no done within %0d cycles", BUDGET); end
    pop_expected(ez, ee);
    n_cmp++;
    if (z !== ez || z !== 32'd445) begin n_bad++; $display("FAIL basic_z: got %0d want %0d", z, ez); end
    n_cmp++;
    if (err !== ee) begin n_bad++; $display("FAIL basic_err: got %b want %b", err, ee); end
    n_cmp++;
    if (rise_total - base !== OPS_4_13) begin
      n_bad++; $display("FAIL basic_ops: got %0d mm_start rises want %0d", rise_total - base, OPS_4_13);
    end
  endtask

  task automatic test_zero_exp;
    int base; bit ok; logic [W-1:0] ez; bit ee;
    base = rise_total;
    issue(32'd3, 32'd0, 32'd7);
    wait_done(ok);
    pop_expected(ez, ee);
    n_cmp++;
    if (!ok || z !== ez || z !== 32'd1) begin n_bad++; $display("FAIL zero_exp_z: got %0d want %0d (done=%b)", z, ez, ok); end
    n_cmp++;
    if (rise_total - base !== OPS_E0) begin
      n_bad++; $display("FAIL zero_exp_ops: got %0d mm_start rises want %0d", rise_total - base, OPS_E0);
    end
  endtask

  task automatic test_mod_one;
    bit ok; logic [W-1:0] ez; bit ee;
    issue(32'd57, 32'd5, 32'd1);
    wait_done(ok);
    pop_expected(ez, ee);
    n_cmp++;
    if (!ok || z !== ez || err !== 1'b0) begin
      n_bad++; $display("FAIL mod_one: got z=%0d err=%b want z=%0d err=0 (done=%b)", z, err, ez, ok);
    end
  endtask

  task automatic test_mod_zero;
    int base; bit ok; logic [W-1:0] ez; bit ee;
    base = rise_total;
    @(negedge clk);
    m_in = 32'd9; e_in = 32'd4; n_in = 32'd0; start = 1'b1;
    exp_z_q.push_back(ref_modexp(32'd9, 32'd4, 32'd0));
    exp_err_q.push_back(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin ok = 1'b1; break; end
    end
    pop_expected(ez, ee);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mod_zero_latency: done not seen within 3 cycles of start"); end
    n_cmp++;
    if (z !== ez || err !== ee) begin n_bad++; $display("FAIL mod_zero_result: got z=%0d err=%b want z=%0d err=%b", z, err, ez, ee); end
    @(negedge clk);
    n_cmp++;
    if (rise_total != base || busy !== 1'b0) begin
      n_bad++; $display("FAIL mod_zero_idle: got %0d mm_start rises busy=%b want 0 rises busy=0", rise_total - base, busy);
    end
  endtask

  task automatic test_busy_ignore;
    int dbase; bit ok; logic [W-1:0] ez; bit ee;
    dbase = done_total;
    issue(32'd2, 32'd10, 32'd1000);
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL busy_accept: got err=%b busy=%b want err=0 busy=1", err, busy); end
    repeat (20) @(negedge clk);
    m_in = 32'd3; e_in = 32'd3; n_in = 32'd11; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    pop_expected(ez, ee);
    n_cmp++;
    if (!ok || z !== ez || z !== 32'd24) begin n_bad++; $display("FAIL busy_z: got %0d want %0d (done=%b)", z, ez, ok); end
    repeat (60) @(negedge clk);
    n_cmp++;
    if (done_total - dbase !== 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_single_done: got %0d done pulses busy=%b want 1 pulse busy=0", done_total - dbase, busy);
    end
  endtask

  task automatic test_back_to_back;
    bit ok; logic [W-1:0] ez; bit ee;
    issue(32'd7775, 32'd714, 32'd779);
    wait_done(ok);
    pop_expected(ez, ee);
    n_cmp++;
    if (!ok || z !== ez || err !== ee) begin n_bad++; $display("FAIL b2b_first: got z=%0d err=%b want z=%0d err=%b", z, err, ez, ee); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_fin: got busy=%b want 1", busy); end
    m_in = 32'd3115; e_in = 32'd2117; n_in = 32'd911; start = 1'b1;
    exp_z_q.push_back(ref_modexp(32'd3115, 32'd2117, 32'd911));
    exp_err_q.push_back(1'b0);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle_gap: got busy=%b err=%b done=%b want 0 0 0", busy, err, done);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
    wait_done(ok);
    pop_expected(ez, ee);
    n_cmp++;
    if (!ok || z !== ez || err !== ee) begin n_bad++; $display("FAIL b2b_second: got z=%0d err=%b want z=%0d err=%b", z, err, ez, ee); end
  endtask

  task automatic test_reset_mid;
    int base; bit ok; logic [W-1:0] ez; bit ee;
    base = rise_total;
    issue(32'd4, 32'd13, 32'd497);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (rise_total - base >= 10) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL reset_mid_reach: only %0d squares issued", rise_total - base); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mm_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got mm_start=%b busy=%b done=%b want 0 0 0", mm_start, busy, done);
    end
    exp_z_q.delete();
    exp_err_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd4, 32'd13, 32'd497);
    wait_done(ok);
    pop_expected(ez, ee);
    n_cmp++;
    if (!ok || z !== ez || z !== 32'd445) begin n_bad++; $display("FAIL reset_mid_rerun: got %0d want %0d (done=%b)", z, ez, ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_exp();
    test_mod_one();
    test_mod_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
